// File: rtl/lfsr_checker_if.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_checker_if
//  Description : Stream and status signals of the PRBS-16 checker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_checker_if;
    logic       ena;
    logic       din;
    logic       din_valid;
    logic       clr_err;
    logic       locked;
    logic       bit_err;
    logic [7:0] err_cnt;
    logic [1:0] state;

    modport master (
        output ena, din, din_valid, clr_err,
        input  locked, bit_err, err_cnt, state
    );

    modport slave (
        input  ena, din, din_valid, clr_err,
        output locked, bit_err, err_cnt, state
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_checker
//  Description : Serial PRBS-16 (x^16+x^14+x^13+x^11+1) lock and error checker.
//                Define LFSR_CHECKER_ERRSAT_EN to saturate err_cnt at 255.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
    parameter int LOCK_LEN = 32,
    parameter int WIN_LEN  = 16,
    parameter int WIN_ERR  = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    lfsr_checker_if.slave bus
);
    localparam int c_run_w  = $clog2(LOCK_LEN + 1);
    localparam int c_wbit_w = $clog2(WIN_LEN + 1);
    localparam int c_werr_w = $clog2(WIN_ERR + 1);

    localparam logic [3:0]          c_load_last = 4'd15;
    localparam logic [c_run_w-1:0]  c_run_last  = c_run_w'(LOCK_LEN - 1);
    localparam logic [c_wbit_w-1:0] c_wbit_last = c_wbit_w'(WIN_LEN - 1);
    localparam logic [c_werr_w-1:0] c_werr_last = c_werr_w'(WIN_ERR - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        LOCKED = 2'd3
    } state_t;

    state_t              r_state;
    logic [16:1]         r_sr;
    logic [3:0]          r_load_cnt;
    logic [c_run_w-1:0]  r_run_cnt;
    logic [c_wbit_w-1:0] r_win_bits;
    logic [c_werr_w-1:0] r_win_errs;
    logic [7:0]          r_err_cnt;
    logic                r_bit_err;
    logic                r_locked;

    state_t              w_state_nxt;
    logic [16:1]         w_sr_nxt;
    logic [3:0]          w_load_nxt;
    logic [c_run_w-1:0]  w_run_nxt;
    logic [c_wbit_w-1:0] w_wbits_nxt;
    logic [c_werr_w-1:0] w_werrs_nxt;
    logic [7:0]          w_err_nxt;
    logic                w_bit_err_nxt;
    logic                w_sample;
    logic                w_pred;
    logic                w_miss;

    always_comb begin
        w_sample      = bus.ena && bus.din_valid;
        w_pred        = r_sr[16] ^ r_sr[14] ^ r_sr[13] ^ r_sr[11];
        w_miss        = bus.din ^ w_pred;
        w_state_nxt   = r_state;
        w_sr_nxt      = r_sr;
        w_load_nxt    = r_load_cnt;
        w_run_nxt     = r_run_cnt;
        w_wbits_nxt   = r_win_bits;
        w_werrs_nxt   = r_win_errs;
        w_bit_err_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.ena) w_state_nxt = LOAD;
            end
            LOAD: begin
                if (w_sample) begin
                    w_sr_nxt = {r_sr[15:1], bus.din};
                    if (r_load_cnt == c_load_last) begin
                        // An all-zero history is the LFSR lock-up state: reload instead.
                        w_load_nxt = '0;
                        if (w_sr_nxt != '0) begin
                            w_state_nxt = VERIFY;
                            w_run_nxt   = '0;
                        end
                    end else begin
                        w_load_nxt = r_load_cnt + 4'd1;
                    end
                end
            end
            VERIFY: begin
                if (w_sample) begin
                    w_sr_nxt = {r_sr[15:1], bus.din};
                    if (w_miss) begin
                        w_state_nxt = LOAD;
                        w_load_nxt  = '0;
                        w_run_nxt   = '0;
                    end else if (r_run_cnt == c_run_last) begin
                        w_state_nxt = LOCKED;
                        w_run_nxt   = '0;
                        w_wbits_nxt = '0;
                        w_werrs_nxt = '0;
                    end else begin
                        w_run_nxt = r_run_cnt + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (w_sample) begin
                    // Flywheel: the history follows the prediction, not the line.
                    w_sr_nxt      = {r_sr[15:1], w_pred};
                    w_bit_err_nxt = w_miss;
                    if (w_miss && (r_win_errs == c_werr_last)) begin
                        w_state_nxt = LOAD;
                        w_load_nxt  = '0;
                        w_wbits_nxt = '0;
                        w_werrs_nxt = '0;
                    end else if (r_win_bits == c_wbit_last) begin
                        w_wbits_nxt = '0;
                        w_werrs_nxt = '0;
                    end else begin
                        w_wbits_nxt = r_win_bits + 1'b1;
                        w_werrs_nxt = r_win_errs + c_werr_w'(w_miss);
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        w_err_nxt = r_err_cnt;
        if (bus.clr_err) begin
            w_err_nxt = '0;
        end else if (w_bit_err_nxt) begin
`ifdef LFSR_CHECKER_ERRSAT_EN
            if (r_err_cnt != 8'hFF) w_err_nxt = r_err_cnt + 8'd1;
`else
            w_err_nxt = r_err_cnt + 8'd1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sr       <= '0;
            r_load_cnt <= '0;
            r_run_cnt  <= '0;
            r_win_bits <= '0;
            r_win_errs <= '0;
            r_err_cnt  <= '0;
            r_bit_err  <= 1'b0;
            r_locked   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sr       <= w_sr_nxt;
            r_load_cnt <= w_load_nxt;
            r_run_cnt  <= w_run_nxt;
            r_win_bits <= w_wbits_nxt;
            r_win_errs <= w_werrs_nxt;
            r_err_cnt  <= w_err_nxt;
            r_bit_err  <= w_bit_err_nxt;
            r_locked   <= (w_state_nxt == LOCKED);
        end
    end

    assign bus.locked  = r_locked;
    assign bus.bit_err = r_bit_err;
    assign bus.err_cnt = r_err_cnt;
    assign bus.state   = r_state;
endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr_checker
//  Description : Self-checking bench for lfsr_checker against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;
    localparam int LOCK_LEN = 32;
    localparam int WIN_LEN  = 16;
    localparam int WIN_ERR  = 4;

    logic clk;
    logic rst;
    lfsr_checker_if bus();

    lfsr_checker #(
        .LOCK_LEN(LOCK_LEN),
        .WIN_LEN (WIN_LEN),
        .WIN_ERR (WIN_ERR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;
    int pulses = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit hist[$];            // hist[k-1] is the bit received k valid samples ago
    int m_state, m_load, m_run, m_win, m_werr, m_err;
    bit m_biterr;

    function automatic int exp_err();
`ifdef LFSR_CHECKER_ERRSAT_EN
        return (m_err > 255) ? 255 : m_err;
`else
        return m_err % 256;
`endif
    endfunction

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < 16; i++) hist.push_back(1'b0);
        m_state = 0; m_load = 0; m_run = 0; m_win = 0; m_werr = 0; m_err = 0;
        m_biterr = 1'b0;
    endtask

    task automatic push_bit(input bit b);
        hist.push_front(b);
        void'(hist.pop_back());
    endtask

    task automatic model_step(input bit r, input bit e, input bit d, input bit v, input bit c);
        bit pred, smp, miss;
        int ones;
        if (r) begin
            model_reset();
            return;
        end
        m_biterr = 1'b0;
        smp  = e && v;
        pred = hist[15] ^ hist[13] ^ hist[12] ^ hist[10];
        miss = (d != pred);
        case (m_state)
            0: if (e) m_state = 1;
            1: if (smp) begin
                push_bit(d);
                m_load++;
                if (m_load == 16) begin
                    m_load = 0;
                    ones = 0;
                    foreach (hist[i]) ones += int'(hist[i]);
                    if (ones != 0) begin m_state = 2; m_run = 0; end
                end
            end
            2: if (smp) begin
                push_bit(d);
                if (miss) begin
                    m_state = 1; m_load = 0; m_run = 0;
                end else begin
                    m_run++;
                    if (m_run == LOCK_LEN) begin
                        m_state = 3; m_run = 0; m_win = 0; m_werr = 0;
                    end
                end
            end
            default: if (smp) begin
                push_bit(pred);
                m_win++;
                if (miss) begin m_biterr = 1'b1; m_werr++; end
                if (m_werr == WIN_ERR) begin
                    m_state = 1; m_load = 0; m_win = 0; m_werr = 0;
                end else if (m_win == WIN_LEN) begin
                    m_win = 0; m_werr = 0;
                end
            end
        endcase
        if (c) m_err = 0;
        else if (m_biterr) m_err++;
    endtask

    // ---------------- PRBS source ----------------
    logic [15:0] g;
    task automatic next_bit(output bit b);
        b = g[15] ^ g[13] ^ g[12] ^ g[10];
        g = {g[14:0], b};
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit r, input bit e, input bit d, input bit v, input bit c);
        rst = r; bus.ena = e; bus.din = d; bus.din_valid = v; bus.clr_err = c;
        @(posedge clk);
        #1;
        model_step(r, e, d, v, c);
        if (bus.bit_err) pulses++;
    endtask

    task automatic feed(input bit flip);
        bit b;
        next_bit(b);
        step(1'b0, 1'b1, b ^ flip, 1'b1, 1'b0);
    endtask

    task automatic align_window();
        for (int i = 0; i < WIN_LEN && m_win != 0; i++) feed(1'b0);
        check("window_align", m_win, 0);
    endtask

    task automatic restart();
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // IDLE -> LOAD, no bit consumed
        g = 16'hACE1;
    endtask

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (chk_on) begin
            check("state",   int'(bus.state),   m_state);
            check("locked",  int'(bus.locked),  int'(m_state == 3));
            check("bit_err", int'(bus.bit_err), int'(m_biterr));
            check("err_cnt", int'(bus.err_cnt), exp_err());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b;
        int vbits;
        rst = 1'b0; bus.ena = 1'b0; bus.din = 1'b0; bus.din_valid = 1'b0; bus.clr_err = 1'b0;
        g = 16'hACE1;

        // Reset with toggling input
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        check("rst_state",   int'(bus.state),   0);
        check("rst_locked",  int'(bus.locked),  0);
        check("rst_err_cnt", int'(bus.err_cnt), 0);
        check("rst_bit_err", int'(bus.bit_err), 0);
        chk_on = 1'b1;

        // Clean continuous stream
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("idle_to_load", int'(bus.state), 1);
        for (int i = 1; i <= 2000; i++) begin
            feed(1'b0);
            if (i == 47) check("clean_locked_at_47", int'(bus.locked), 0);
            if (i == 48) check("clean_locked_at_48", int'(bus.locked), 1);
        end
        check("clean_err_cnt", int'(bus.err_cnt), 0);
        check("clean_locked_end", int'(bus.locked), 1);

        // Gapped stream: valid toggles 1,0
        restart();
        for (int i = 1; i <= 100; i++) begin
            feed(1'b0);
            if (i == 47) check("gap_locked_at_47", int'(bus.locked), 0);
            if (i == 48) check("gap_locked_at_48", int'(bus.locked), 1);
            step(1'b0, 1'b1, i[0], 1'b0, 1'b0);
        end

        // Three errors inside one window
        align_window();
        pulses = 0;
        for (int k = 0; k < WIN_LEN; k++) feed(k == 2 || k == 5 || k == 9);
        check("sub_pulses",  pulses, 3);
        check("sub_err_cnt", int'(bus.err_cnt), 3);
        check("sub_locked",  int'(bus.locked), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check("clr_err_cnt", int'(bus.err_cnt), 0);

        // Four errors inside one window -> loss of lock
        align_window();
        for (int k = 0; k <= 10; k++) feed(k == 1 || k == 4 || k == 7 || k == 10);
        check("loss_locked",  int'(bus.locked), 0);
        check("loss_state",   int'(bus.state), 1);
        check("loss_err_cnt", int'(bus.err_cnt), 4);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("stuck_state", int'(bus.state), 1);

        // Relock, then one error per window for 300 windows
        for (int i = 0; i < 600 && m_state != 3; i++) feed(1'b0);
        check("relock", int'(bus.locked), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        align_window();
        for (int w = 0; w < 300; w++) begin
            int pos;
            pos = $urandom_range(WIN_LEN - 1, 0);
            for (int k = 0; k < WIN_LEN; k++) feed(k == pos);
        end
        check("wrap_locked", int'(bus.locked), 1);
`ifdef LFSR_CHECKER_ERRSAT_EN
        check("wrap_err_cnt", int'(bus.err_cnt), 255);
`else
        check("wrap_err_cnt", int'(bus.err_cnt), 44);
`endif

        // Randomised traffic: enable/valid gaps, sparse errors, clears, resets
        for (int i = 0; i < 4000; i++) begin
            bit e, v, c, r, f;
            r = ($urandom_range(599, 0) == 0);
            e = ($urandom_range(9, 0) != 0);
            v = ($urandom_range(9, 0) < 7);
            c = ($urandom_range(99, 0) == 0);
            f = ($urandom_range(39, 0) == 0);
            if (e && v) begin
                next_bit(b);
                b = b ^ f;
            end else begin
                b = 1'($urandom_range(1, 0));
            end
            step(r, e, b, v, c);
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The module SHALL have a parameter LOCK_LEN, default 32, giving the number of consecutive matching bits required in VERIFY to reach LOCKED.
REQ-002 The module SHALL have a parameter WIN_LEN, default 16, giving the error-window length in valid bits.
REQ-003 The module SHALL have a parameter WIN_ERR, default 4, giving the number of errors within one window that causes loss of lock.
REQ-004 Port clk SHALL be an input, 1 bit wide: the single clock, rising edge.
REQ-005 Port rst SHALL be an input, 1 bit wide: reset, synchronous and active-high.
REQ-006 Port ena SHALL be an input, 1 bit wide: block enable; when 0, all state SHALL hold.
REQ-007 Port din SHALL be an input, 1 bit wide: serial received PRBS bit.
REQ-008 Port din_valid SHALL be an input, 1 bit wide: din is sampled on a rising edge only when din_valid=1 and ena=1.
REQ-009 Port clr_err SHALL be an input, 1 bit wide: synchronous clear of err_cnt.
REQ-010 Port locked SHALL be an output, 1 bit wide: 1 while state is LOCKED.
REQ-011 Port bit_err SHALL be an output, 1 bit wide: one-cycle pulse per mismatched bit while LOCKED.
REQ-012 Port err_cnt SHALL be an output, 8 bits wide: accumulated error count.
REQ-013 Port state SHALL be an output, 2 bits wide: debug state, encoded IDLE=0, LOAD=1, VERIFY=2, LOCKED=3.

Function
REQ-014 The checked sequence SHALL obey b[n] = b[n-16] ^ b[n-14] ^ b[n-13] ^ b[n-11] (16-bit maximal length, period 65535).
REQ-015 Predicted bit p SHALL be the XOR of taps 16, 14, 13 and 11 of a 16-bit history register sr, where sr[1] is the most recent bit.
REQ-016 IDLE: the FSM SHALL move to LOAD on the first cycle with ena=1.
REQ-017 LOAD: each valid bit SHALL shift din into sr; after 16 valid bits the FSM SHALL go to VERIFY, unless sr is all-zero, in which case the load count SHALL restart and the FSM SHALL stay in LOAD.
REQ-018 VERIFY: each valid bit SHALL shift din into sr and compare din with p; a match SHALL increment the run counter, and reaching LOCK_LEN SHALL enter LOCKED; any mismatch SHALL return to LOAD with the load count cleared.
REQ-019 LOCKED: each valid bit SHALL shift p (not din) into sr (flywheel); din != p SHALL pulse bit_err and increment err_cnt and the window error count.
REQ-020 A window SHALL span WIN_LEN valid bits from lock entry; at the window end both the window bit count and the window error count SHALL clear.
REQ-021 When the window error count reaches WIN_ERR, the FSM SHALL go to LOAD and locked SHALL fall on the next edge; err_cnt SHALL be retained.
REQ-022 All outputs SHALL be registered, and SHALL reflect a sampled bit on the edge following the sample, i.e. one cycle of latency.
REQ-023 Gaps in din_valid SHALL NOT advance any counter, sr, or window.
REQ-024 When clr_err=1, err_cnt SHALL be 0 on the next edge; clr_err SHALL have priority over a simultaneous error, and bit_err SHALL still pulse.
REQ-025 clr_err SHALL act regardless of ena.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, sr=0, all counters=0, locked=0, bit_err=0, err_cnt=0.
REQ-027 rst SHALL override ena, din_valid and clr_err.
REQ-028 rst asserted mid-lock SHALL drop locked on the same edge.

Configuration
REQ-029 With macro LFSR_CHECKER_ERRSAT_EN defined, err_cnt SHALL saturate at 255.
REQ-030 Without LFSR_CHECKER_ERRSAT_EN, err_cnt SHALL wrap from 255 to 0.

Verification
REQ-031 Reset test: assert rst for 2 cycles with din toggling -> state=0, locked=0, err_cnt=0x00, bit_err=0.
REQ-032 Clean stream test: drive the PRBS generated from seed 0xACE1 with din_valid=1 continuous -> locked=1 on the edge after the 48th valid bit; err_cnt stays 0 over 2000 bits.
REQ-033 Gapped stream test: repeat the clean stream test with din_valid toggling 1,0 -> lock after 48 valid bits (about 96 cycles); state holds during gaps.
REQ-034 Sub-threshold error test: when locked, flip 3 bits within one 16-bit window -> 3 bit_err pulses, err_cnt=3, locked stays 1; then apply clr_err -> err_cnt=0.
REQ-035 Lock-loss and stuck-input test: flip 4 bits within one window -> locked=0, state=1, err_cnt=4; then drive 100 zero bits -> state remains 1.
REQ-036 Counter wrap/saturation test: inject 300 errors, one per window -> lock held; err_cnt=255 with LFSR_CHECKER_ERRSAT_EN, 44 without.
